// File: rtl/usb_dfu_flash_ctrl_if.sv
// rtl/usb_dfu_flash_ctrl_if.sv - DFU handler and SPI flash bridge signals of the flash sequencer
interface usb_dfu_flash_ctrl_if #(
  parameter int LEN_BITS = 9
);
  logic                dn_start;
  logic                up_start;
  logic                abort;
  logic [15:0]         block_num;
  logic [LEN_BITS-1:0] length;
  logic                busy;
  logic                done;
  logic                error;
  logic                manifest;
  logic [LEN_BITS-1:0] byte_count;
  logic [15:0]         flash_address;
  logic                flash_rd_request;
  logic                flash_wr_request;
  logic                flash_rd_data_put;
  logic                flash_wr_data_get;
  logic                flash_wr_busy;

  modport master (
    output dn_start, up_start, abort, block_num, length,
    output flash_rd_data_put, flash_wr_data_get, flash_wr_busy,
    input  busy, done, error, manifest, byte_count,
    input  flash_address, flash_rd_request, flash_wr_request
  );

  modport slave (
    input  dn_start, up_start, abort, block_num, length,
    input  flash_rd_data_put, flash_wr_data_get, flash_wr_busy,
    output busy, done, error, manifest, byte_count,
    output flash_address, flash_rd_request, flash_wr_request
  );
endinterface

// File: rtl/usb_dfu_flash_ctrl.sv
// rtl/usb_dfu_flash_ctrl.sv - turns one DFU DNLOAD/UPLOAD block into one SPI flash page transaction
module usb_dfu_flash_ctrl #(
  parameter int          PAGE_SIZE  = 256,
  parameter logic [15:0] BASE_PAGE  = 16'h0800,
  parameter logic [15:0] MAX_BLOCKS = 16'h0800,
  parameter int          LEN_BITS   = 9
) (
  input logic                 clk,
  input logic                 reset,
  usb_dfu_flash_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WR_ARM, WR_DATA, WR_DRAIN, RD_DATA, RD_STOP} state_e;

  localparam logic [LEN_BITS-1:0] PAGE_LEN = LEN_BITS'(PAGE_SIZE);
  localparam logic [1:0]          ARM_LAST = 2'd3;

  state_e              state_q, state_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [LEN_BITS-1:0] byte_count_q, byte_count_d;
  logic [15:0]         flash_address_q, flash_address_d;
  logic [1:0]          arm_cnt_q, arm_cnt_d;
  logic                error_q, error_d;
  logic                done_q, done_d;
  logic                manifest_q, manifest_d;
  logic                aborted_q, aborted_d;
  logic [LEN_BITS-1:0] count_inc;

  assign count_inc = byte_count_q + LEN_BITS'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      len_q           <= '0;
      byte_count_q    <= '0;
      flash_address_q <= BASE_PAGE;
      arm_cnt_q       <= '0;
      error_q         <= 1'b0;
      done_q          <= 1'b0;
      manifest_q      <= 1'b0;
      aborted_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      byte_count_q    <= byte_count_d;
      flash_address_q <= flash_address_d;
      arm_cnt_q       <= arm_cnt_d;
      error_q         <= error_d;
      done_q          <= done_d;
      manifest_q      <= manifest_d;
      aborted_q       <= aborted_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    byte_count_d    = byte_count_q;
    flash_address_d = flash_address_q;
    arm_cnt_d       = arm_cnt_q;
    error_d         = error_q;
    aborted_d       = aborted_q;
    done_d          = 1'b0;
    manifest_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.dn_start || bus.up_start) begin
          len_d           = bus.length;
          byte_count_d    = '0;
          error_d         = 1'b0;
          aborted_d       = 1'b0;
          arm_cnt_d       = '0;
          flash_address_d = BASE_PAGE + bus.block_num;
          // Range check uses the raw block number, not the wrapped page address.
          if (bus.block_num >= MAX_BLOCKS || bus.length > PAGE_LEN) begin
            error_d = 1'b1;
          end else if (bus.length == '0) begin
            if (bus.dn_start) manifest_d = 1'b1;
            else              done_d     = 1'b1;
          end else if (bus.dn_start) begin
            state_d = WR_ARM;
          end else begin
            state_d = RD_DATA;
          end
        end else if (bus.abort) begin
          error_d = 1'b0;
        end
      end
      WR_ARM: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = WR_DRAIN;
        end else if (bus.flash_wr_busy) begin
          state_d = WR_DATA;
        end else if (arm_cnt_q == ARM_LAST) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          arm_cnt_d = arm_cnt_q + 2'd1;
        end
      end
      WR_DATA: begin
        if (bus.flash_wr_data_get && byte_count_q != len_q) byte_count_d = count_inc;
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = WR_DRAIN;
        end else if (bus.flash_wr_data_get && count_inc == len_q) begin
          state_d = WR_DRAIN;
        end
      end
      // An erase/program in flight cannot be cancelled, so even an abort waits here.
      WR_DRAIN: begin
        if (!bus.flash_wr_busy) begin
          state_d = IDLE;
          done_d  = !aborted_q;
        end
      end
      RD_DATA: begin
        if (bus.flash_rd_data_put && byte_count_q != len_q) byte_count_d = count_inc;
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.flash_rd_data_put && count_inc == len_q) begin
          state_d = RD_STOP;
        end
      end
      RD_STOP: begin
        state_d = IDLE;
        done_d  = !bus.abort;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy             = (state_q != IDLE);
  assign bus.done             = done_q;
  assign bus.error            = error_q;
  assign bus.manifest         = manifest_q;
  assign bus.byte_count       = byte_count_q;
  assign bus.flash_address    = flash_address_q;
  assign bus.flash_wr_request = (state_q == WR_ARM) || (state_q == WR_DATA);
  assign bus.flash_rd_request = (state_q == RD_DATA);
endmodule

// File: tb/tb_usb_dfu_flash_ctrl.sv
// tb/tb_usb_dfu_flash_ctrl.sv - directed self-checking bench for usb_dfu_flash_ctrl
module tb_usb_dfu_flash_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic seen;

  always #5 clk = ~clk;

  usb_dfu_flash_ctrl_if #(.LEN_BITS(9)) bus ();

  usb_dfu_flash_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic dn, input logic up, input logic [15:0] bn, input logic [8:0] len);
    bus.dn_start  = dn;
    bus.up_start  = up;
    bus.block_num = bn;
    bus.length    = len;
    tick();
    bus.dn_start = 1'b0;
    bus.up_start = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  initial begin
    bus.dn_start = 0; bus.up_start = 0; bus.abort = 0;
    bus.block_num = '0; bus.length = '0;
    bus.flash_rd_data_put = 0; bus.flash_wr_data_get = 0; bus.flash_wr_busy = 0;

    tick(); tick();
    reset = 1'b1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    check("rst_manifest", bus.manifest, 0);
    check("rst_byte_count", bus.byte_count, 0);
    check("rst_addr", bus.flash_address, 32'h0800);
    check("rst_rd_req", bus.flash_rd_request, 0);
    check("rst_wr_req", bus.flash_wr_request, 0);

    // Full-page DNLOAD to block 3
    start(1, 0, 16'd3, 9'd256);
    check("dn_wr_req", bus.flash_wr_request, 1);
    check("dn_addr", bus.flash_address, 32'h0803);
    check("dn_busy", bus.busy, 1);
    bus.flash_wr_busy = 1'b1;
    tick();
    seen = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bus.flash_wr_data_get = 1'b1;
      if (!bus.flash_wr_request || bus.flash_rd_request) seen = 1'b1;
      tick();
    end
    bus.flash_wr_data_get = 1'b0;
    check("dn_req_held_during_data", seen, 0);
    check("dn_wr_req_drop", bus.flash_wr_request, 0);
    check("dn_byte_count", bus.byte_count, 256);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done || !bus.busy) seen = 1'b1;
      tick();
    end
    check("dn_drain_wait", seen, 0);
    bus.flash_wr_busy = 1'b0;
    tick();
    check("dn_done", bus.done, 1);
    check("dn_idle", bus.busy, 0);
    tick();
    check("dn_done_pulse", bus.done, 0);
    check("dn_byte_count_hold", bus.byte_count, 256);

    // UPLOAD 64 bytes from block 0
    start(0, 1, 16'd0, 9'd64);
    check("up_rd_req", bus.flash_rd_request, 1);
    check("up_addr", bus.flash_address, 32'h0800);
    check("up_byte_count_clr", bus.byte_count, 0);
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      bus.flash_rd_data_put = 1'b1;
      if (bus.flash_wr_request || !bus.flash_rd_request) seen = 1'b1;
      tick();
    end
    bus.flash_rd_data_put = 1'b0;
    check("up_req_held", seen, 0);
    check("up_rd_req_drop", bus.flash_rd_request, 0);
    check("up_stop_busy", bus.busy, 1);
    check("up_no_early_done", bus.done, 0);
    tick();
    check("up_done", bus.done, 1);
    check("up_byte_count", bus.byte_count, 64);
    check("up_idle", bus.busy, 0);

    // Zero-length requests
    start(1, 0, 16'd5, 9'd0);
    check("man_pulse", bus.manifest, 1);
    check("man_no_req", {bus.flash_wr_request, bus.flash_rd_request}, 0);
    check("man_busy", bus.busy, 0);
    tick();
    check("man_pulse_end", bus.manifest, 0);
    start(0, 1, 16'd5, 9'd0);
    check("up0_done", bus.done, 1);
    check("up0_busy", bus.busy, 0);
    check("up0_no_req", {bus.flash_wr_request, bus.flash_rd_request}, 0);

    // Range errors and abort clearing
    start(1, 0, 16'h0800, 9'd16);
    check("blk_err", bus.error, 1);
    check("blk_err_no_req", {bus.flash_wr_request, bus.flash_rd_request, bus.busy, bus.done}, 0);
    tick();
    check("blk_err_sticky", bus.error, 1);
    pulse_abort();
    check("blk_err_abort_clr", bus.error, 0);
    start(0, 1, 16'd1, 9'd257);
    check("len_err", bus.error, 1);
    check("len_err_no_req", {bus.flash_rd_request, bus.busy}, 0);
    pulse_abort();
    check("len_err_abort_clr", bus.error, 0);

    // Last valid block with full page, then abort the read
    start(0, 1, 16'h07FF, 9'd256);
    check("lastblk_rd_req", bus.flash_rd_request, 1);
    check("lastblk_addr", bus.flash_address, 32'h0FFF);
    check("lastblk_no_err", bus.error, 0);
    pulse_abort();
    check("rd_abort_req", {bus.flash_rd_request, bus.busy, bus.done}, 0);
    tick();
    check("rd_abort_no_done", bus.done, 0);

    // Abort mid-write: drain must still wait for the bridge
    start(1, 0, 16'd7, 9'd100);
    bus.flash_wr_busy = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.flash_wr_data_get = 1'b1;
      tick();
    end
    bus.flash_wr_data_get = 1'b0;
    pulse_abort();
    check("wab_wr_req", bus.flash_wr_request, 0);
    check("wab_busy", bus.busy, 1);
    check("wab_count", bus.byte_count, 10);
    seen = 1'b0;
    for (int i = 0; i < 38; i++) begin
      if (!bus.busy || bus.done) seen = 1'b1;
      tick();
    end
    check("wab_drain_wait", seen, 0);
    bus.flash_wr_busy = 1'b0;
    tick();
    check("wab_idle", bus.busy, 0);
    check("wab_no_done", bus.done, 0);
    tick();
    check("wab_no_done2", {bus.done, bus.error}, 0);

    // Simultaneous starts take the write path; a start mid-write is ignored
    start(1, 1, 16'd2, 9'd8);
    check("both_wr", bus.flash_wr_request, 1);
    check("both_no_rd", bus.flash_rd_request, 0);
    bus.flash_wr_busy = 1'b1;
    tick();
    start(0, 1, 16'd9, 9'd4);
    check("ign_rd", bus.flash_rd_request, 0);
    check("ign_wr", bus.flash_wr_request, 1);
    check("ign_addr", bus.flash_address, 32'h0802);
    for (int i = 0; i < 8; i++) begin
      bus.flash_wr_data_get = 1'b1;
      tick();
    end
    bus.flash_wr_data_get = 1'b0;
    check("both_count", bus.byte_count, 8);
    check("both_wr_drop", bus.flash_wr_request, 0);
    bus.flash_wr_busy = 1'b0;
    tick();
    check("both_done", bus.done, 1);

    // Bridge never goes busy: arm timeout after four cycles
    start(1, 0, 16'd1, 9'd4);
    tick(); tick(); tick();
    check("arm_wait_req", bus.flash_wr_request, 1);
    tick();
    check("arm_to_req", bus.flash_wr_request, 0);
    check("arm_to_err", bus.error, 1);
    check("arm_to_idle", {bus.busy, bus.done}, 0);
    pulse_abort();
    check("arm_err_clr", bus.error, 0);

    // Reset mid-read
    start(0, 1, 16'd4, 9'd32);
    for (int i = 0; i < 5; i++) begin
      bus.flash_rd_data_put = 1'b1;
      tick();
    end
    bus.flash_rd_data_put = 1'b0;
    check("mid_count", bus.byte_count, 5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mrst_outs", {bus.busy, bus.done, bus.error, bus.manifest,
                        bus.flash_rd_request, bus.flash_wr_request}, 0);
    check("mrst_count", bus.byte_count, 0);
    check("mrst_addr", bus.flash_address, 32'h0800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/usb_dfu_flash_ctrl.md
Name: usb_dfu_flash_ctrl

Overview:
Sequences the SPI flash bridge on behalf of the DFU request handler. It turns one DFU DNLOAD or UPLOAD block request into one flash page transaction. For that transaction it drives the bridge page address and read/write request levels, counts bytes moved, and waits out erase/program. It reports done, error and busy status back to the handler, which maps them onto DFU state and status.

Parameters:
PAGE_SIZE, 256, flash page size in bytes; also the maximum DFU transfer size.
BASE_PAGE, 16'h0800, flash page holding DFU block 0 (image start offset).
MAX_BLOCKS, 16'h0800, number of DFU blocks allowed; block_num >= MAX_BLOCKS is an error.
LEN_BITS, 9, width of the length and byte counters; holds values 0..PAGE_SIZE.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
dn_start  in  1  one-cycle pulse: start a DNLOAD block
up_start  in  1  one-cycle pulse: start an UPLOAD block
abort  in  1  one-cycle pulse: DFU_ABORT / CLRSTATUS
block_num  in  16  DFU wBlockNum; sampled on start
length  in  LEN_BITS  DFU wLength; sampled on start
busy  out  1  transaction in progress
done  out  1  one-cycle pulse when a transaction completes normally
error  out  1  sticky error; cleared by the next accepted start or by abort
manifest  out  1  one-cycle pulse: zero-length DNLOAD (end of image)
byte_count  out  LEN_BITS  bytes moved in the current/last transaction
flash_address  out  16  bridge page address, registered
flash_rd_request  out  1  bridge read request level
flash_wr_request  out  1  bridge write request level
flash_rd_data_put  in  1  bridge delivered one read byte
flash_wr_data_get  in  1  bridge consumed one write byte
flash_wr_busy  in  1  bridge erasing/programming

Behaviour:
- Reset (reset=0 at posedge): state=IDLE. All outputs are 0, except flash_address, which resets to BASE_PAGE.
- States: IDLE, WR_ARM, WR_DATA, WR_DRAIN, RD_DATA, RD_STOP.
- Starts are accepted only in IDLE. Starts in any other state are ignored.
  - dn_start and up_start in the same cycle: dn_start wins.
- Accepted start:
  - latch len=length and clear byte_count and error.
  - flash_address <= BASE_PAGE + block_num, 16-bit with wrap; the range check runs on the unwrapped block_num.
- Start checks, in order:
  - block_num >= MAX_BLOCKS or length > PAGE_SIZE: error<=1 next cycle, no flash request, stay IDLE, no done.
  - dn_start with length==0: manifest pulse next cycle, no flash request.
  - up_start with length==0: done pulse next cycle, no flash request.
- DNLOAD:
  - IDLE -> WR_ARM: flash_wr_request=1, the same cycle flash_address becomes valid.
  - WR_ARM: wait for flash_wr_busy=1, then -> WR_DATA. If wr_busy has not risen within 4 cycles, drop wr_request, set error, return to IDLE.
  - WR_DATA: each flash_wr_data_get increments byte_count.
    - When byte_count+get reaches len, drop flash_wr_request on the next edge and go to WR_DRAIN.
    - gets arriving after len are counted only up to len; a protocol violation, no error.
  - WR_DRAIN: wait for flash_wr_busy=0 -> done pulse, IDLE.
- UPLOAD:
  - IDLE -> RD_DATA: flash_rd_request=1.
  - RD_DATA: each flash_rd_data_put increments byte_count.
  - On the put that makes byte_count==len: drop flash_rd_request on the next edge and go to RD_STOP.
  - RD_STOP: one cycle, lets the bridge return to idle -> done pulse, IDLE.
- busy=1 in every non-IDLE state.
- flash_rd_request and flash_wr_request are never both 1.
- Abort:
  - RD_DATA / RD_STOP: drop rd_request next edge, go to IDLE, no done.
  - WR_ARM / WR_DATA: drop wr_request next edge, go to WR_DRAIN. A program/erase cannot be cancelled.
    - On WR_DRAIN exit after an abort: no done pulse, return to IDLE.
  - IDLE: clears error.
- Reset mid-transaction: requests drop at that edge. The bridge's own reset is expected to be asserted in the same cycle.
- byte_count holds its final value until the next accepted start.

Test Plan:
- DNLOAD block_num=3, length=256, bench issues 256 wr_data_get, wr_busy high 20 cycles after the last get -> flash_address=0x0803; wr_request drops one cycle after get #256; done pulses one cycle after wr_busy falls; byte_count=256.
- UPLOAD block_num=0, length=64, bench puts 64 bytes -> flash_address=0x0800; rd_request drops the cycle after put #64; done 2 cycles later; byte_count=64; wr_request stays 0.
- dn_start length=0 -> manifest pulse next cycle, no request asserted, busy stays 0. up_start length=0 -> done next cycle.
- block_num=0x0800 -> error=1, no requests. length=257 -> error=1. Following abort -> error=0.
- Abort during WR_DATA after 10 gets, wr_busy held 50 cycles -> wr_request drops next edge; busy stays 1 until wr_busy=0; no done pulse.
- Simultaneous dn_start+up_start -> write path taken; up_start during WR_DATA ignored; reset=0 mid-RD_DATA -> all outputs 0 next edge.
